multicycle_alu: RTL
===================

Name: multicycle_alu

Overview:
- Parametrised, clocked successor to the combinational ALU: same 5-bit opCode map, generic WIDTH, and a valid/ready handshake on both input and output.
- Logic ops, add/sub, compares and shifts complete in one cycle.
- MUL, DIV and MOD run iteratively (one bit per cycle) to save area and shorten the critical path.
- Sits between register-read and writeback in the multi-cycle core; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32: operand and result width (any value >= 4).
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; never overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  ALU can accept; high only in IDLE.
- opCode  input  5  operation, same encoding as the combinational ALU.
- dataA  input  WIDTH  operand A (unsigned).
- dataB  input  WIDTH  operand B (unsigned) or shift amount.
- out_valid  output  1  result available; held until out_ready.
- out_ready  input  1  consumer takes result.
- dataC  output  WIDTH  result.
- zero  output  1  dataC == 0.
- overflow  output  1  ADD carry out / SUB borrow / MUL upper half nonzero; 0 for all other ops.
- error  output  1  DIV or MOD by zero, or illegal opcode (21..31).

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE; in_ready = 1.
  - out_valid, dataC, zero, overflow and error all 0.
  - Any in-flight operation is discarded; no output is produced for it.
- Acceptance:
  - A transaction is accepted on the rising edge where in_valid && in_ready.
  - opCode, dataA and dataB are captured; later input changes are ignored.
- States: IDLE, MUL, DIV, DONE.
- Single-cycle ops:
  - ADD/ADDI, SUB/SUBI, SLT/SLTI, AND/ANDI, OR/ORI, NOT, SHR, SHL, SGT/SGTI, SEQ.
  - IDLE -> DONE; out_valid is high the cycle after acceptance (latency 1).
- Arithmetic and width rules:
  - ADD: WIDTH+1-bit sum; dataC = low WIDTH bits; overflow = bit WIDTH.
  - SUB: dataC = A-B modulo 2^WIDTH; overflow = (A < B).
  - Compares return 0 or 1 zero-extended.
  - Shifts are logical; shift amount is the full dataB, and any value >= WIDTH gives dataC = 0.
- MUL/MULI:
  - IDLE -> MUL; shift-add for exactly WIDTH cycles, then -> DONE.
  - out_valid asserts WIDTH+1 cycles after acceptance.
  - Uses a 2*WIDTH-bit product; dataC = low half; overflow = |high half.
- DIV/DIVI and MOD:
  - dataB == 0: IDLE -> DONE directly (latency 1), dataC = 0, error = 1.
  - Otherwise IDLE -> DIV; restoring division for WIDTH cycles, then -> DONE (latency WIDTH+1).
  - DIV returns the quotient; MOD returns the remainder.
- Illegal opcode: latency 1, dataC = 0, error = 1, overflow = 0.
- Output flags: zero is computed from the final dataC and is valid only with out_valid. error and overflow are independent; overflow does not set error.
- DONE:
  - Outputs are stable while out_valid && !out_ready.
  - On out_ready: -> IDLE, out_valid drops the next cycle, in_ready rises the same edge.
  - No back-to-back acceptance while in DONE; maximum throughput is 1 op per latency+1 cycles.
- Counter:
  - CNT_W bits, loaded with WIDTH on entry to MUL/DIV and decremented each cycle.
  - Exit when it reaches 1 (exactly WIDTH iterations); no wrap-around.
- Between transactions, dataC and the flags hold the last result while out_valid is 0.

Decomposition:
- Package alu_pkg holds:
  - the 5-bit opcode localparams (OP_ADD=0 .. OP_SEQ=20);
  - the state encoding (IDLE, MUL, DIV, DONE);
  - an is_illegal_op function.
- One natural sub-module, seq_divider (WIDTH): a start/done restoring divider returning quotient and remainder.
  - The multiplier datapath stays inline.

Test Plan:
- ADD, WIDTH=32: A=0xFFFFFFFF, B=1 -> out_valid 1 cycle after accept; dataC=0, zero=1, overflow=1, error=0.
- MUL: A=0x00010000, B=0x00010000 -> out_valid exactly 33 cycles after accept; dataC=0, overflow=1, zero=1. A=7, B=6 -> dataC=42, overflow=0.
- DIV/MOD: A=100, B=7 -> DIV gives dataC=14 and MOD gives dataC=2, each at latency 33. A=5, B=0 (DIV) -> latency 1, dataC=0, error=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles after result: dataC stays stable and in_ready stays 0.
  - Change dataA mid-MUL: the result is unaffected.
  - Assert out_ready: in_ready=1 on the next cycle.
- Shift and illegal: SHL A=1, B=31 -> 0x80000000. SHL A=1, B=32 -> 0, zero=1. opCode=5'b11111 -> dataC=0, error=1.
- Reset mid-DIV: drop reset_n at iteration 10 -> out_valid=0 and state IDLE immediately. After release, a new ADD 2+3 returns 5 with no stale output.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, FSM states, opcode legality helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  // 5-bit opcode map shared with the combinational ALU. The immediate variants
  // behave like their register forms; the immediate already arrives on dataB.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBI = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_MULI = 5'd5;
  localparam logic [4:0] OP_DIV  = 5'd6;
  localparam logic [4:0] OP_DIVI = 5'd7;
  localparam logic [4:0] OP_MOD  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_ANDI = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_ORI  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_SHL  = 5'd15;
  localparam logic [4:0] OP_SLT  = 5'd16;
  localparam logic [4:0] OP_SLTI = 5'd17;
  localparam logic [4:0] OP_SGT  = 5'd18;
  localparam logic [4:0] OP_SGTI = 5'd19;
  localparam logic [4:0] OP_SEQ  = 5'd20;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // Opcodes 21..31 are unassigned.
  function automatic logic is_illegal_op(input logic [4:0] op);
    return op > OP_SEQ;
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the core and the multi-cycle ALU.
// Latency: n/a (wiring only). Ports: request (in_valid/in_ready/opCode/dataA/dataB),
// Backpressure: in_ready gates requests; out_ready gates results (dataC, zero, overflow, error).
interface multicycle_alu_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opCode;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dataC;
  logic             zero;
  logic             overflow;
  logic             error;

  // Core side: issues requests, consumes results.
  modport master (
    output in_valid, opCode, dataA, dataB, out_ready,
    input  in_ready, out_valid, dataC, zero, overflow, error
  );

  // ALU side.
  modport slave (
    input  in_valid, opCode, dataA, dataB, out_ready,
    output in_ready, out_valid, dataC, zero, overflow, error
  );

endinterface

// File: rtl/multicycle_alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; ports: start/dividend/divisor in, done/quotient/remainder out.
// Latency: start loads operands; done is high during the WIDTH-th iteration cycle with final results on quotient/remainder.
// Backpressure: none; a new start simply restarts the divider. Divisor must be nonzero.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;   // holds the not-yet-consumed dividend bits, quotient shifts in from the bottom
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Partial remainder stays below the divisor, so after the shift it fits in
  // WIDTH+1 bits and bit WIDTH of the trial difference is a clean borrow flag.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs};
  assign fits    = ~trial[WIDTH];
  assign rem_nxt = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], fits};

  // Results are the next-state values so the parent can capture them on the last iteration edge.
  assign done      = busy && (cnt == CNT_W'(1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WIDTH);
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
    end else if (busy) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub/compare/shift, iterative MUL/DIV/MOD; ports: clock, reset_n, bus (slave).
// Latency: 1 cycle for single-cycle ops, illegal opcodes and divide-by-zero; WIDTH+1 cycles for MUL/DIV/MOD.
// Backpressure: in_ready only in IDLE; result held with out_valid until out_ready, then back to IDLE.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset_n,
  multicycle_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [4:0]         op_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] data_c_q;
  logic             zero_q;
  logic             overflow_q;
  logic             error_q;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_res;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_err;
  logic [WIDTH:0]     sum;
  logic               shamt_big;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0]   mul_lo;

  assign accept    = bus.in_valid && in_ready_q;
  assign is_mul    = (bus.opCode == OP_MUL) || (bus.opCode == OP_MULI);
  assign is_div    = (bus.opCode == OP_DIV) || (bus.opCode == OP_DIVI) || (bus.opCode == OP_MOD);
  // Divide-by-zero never starts the divider; it completes in one cycle with error set.
  assign div_start = accept && is_div && (bus.dataB != '0);

  assign sum       = {1'b0, bus.dataA} + {1'b0, bus.dataB};
  assign shamt_big = bus.dataB >= WIDTH'(WIDTH);
  assign mul_acc   = prod + (mplier[0] ? mcand : '0);
  assign mul_lo    = mul_acc[WIDTH-1:0];
  assign div_res   = (op_q == OP_MOD) ? div_rem : div_quo;

  // Results for everything that finishes in the acceptance cycle.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (bus.opCode)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = sum[WIDTH];
      end
      OP_SUB, OP_SUBI: begin
        alu_res = bus.dataA - bus.dataB;
        alu_ovf = bus.dataA < bus.dataB;
      end
      OP_AND, OP_ANDI: alu_res = bus.dataA & bus.dataB;
      OP_OR,  OP_ORI:  alu_res = bus.dataA | bus.dataB;
      OP_NOT:          alu_res = ~bus.dataA;
      OP_SHR:          alu_res = shamt_big ? '0 : (bus.dataA >> bus.dataB);
      OP_SHL:          alu_res = shamt_big ? '0 : (bus.dataA << bus.dataB);
      OP_SLT, OP_SLTI: alu_res = {{(WIDTH-1){1'b0}}, bus.dataA < bus.dataB};
      OP_SGT, OP_SGTI: alu_res = {{(WIDTH-1){1'b0}}, bus.dataA > bus.dataB};
      OP_SEQ:          alu_res = {{(WIDTH-1){1'b0}}, bus.dataA == bus.dataB};
      OP_MUL, OP_MULI: alu_res = '0;
      OP_DIV, OP_DIVI, OP_MOD: alu_err = 1'b1;  // only reaches the output when dataB == 0
      default:         alu_err = is_illegal_op(bus.opCode);
    endcase
  end

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (bus.dataA),
    .divisor   (bus.dataB),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      prod        <= '0;
      mcand       <= '0;
      mplier      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_c_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= bus.opCode;
            in_ready_q <= 1'b0;
            if (is_mul) begin
              state  <= MUL;
              cnt    <= CNT_W'(WIDTH);
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.dataA};
              mplier <= bus.dataB;
            end else if (div_start) begin
              state <= DIV;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              data_c_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              overflow_q  <= alu_ovf;
              error_q     <= alu_err;
            end
          end
        end
        MUL: begin
          // Shift-add: one multiplier bit per cycle, counter exits on 1 after WIDTH steps.
          prod   <= mul_acc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            data_c_q    <= mul_lo;
            zero_q      <= (mul_lo == '0);
            overflow_q  <= |mul_acc[2*WIDTH-1:WIDTH];
            error_q     <= 1'b0;
          end
        end
        DIV: begin
          if (div_done) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            data_c_q    <= div_res;
            zero_q      <= (div_res == '0);
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dataC     = data_c_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.error     = error_q;

endmodule
